pll_reset_sequencer: RTL and testbench

- Sits directly downstream of the LPDDR2 clock PLL and consumes its `locked` output. It also drives the PLL's active-high `rst` input.
- Runs on the free-running 125 MHz reference clock, so it works while the PLL is unlocked.
- Synchronises and qualifies lock, then releases the PHY, controller and user resets in a fixed order with programmable gaps.
- Watchdogs lock acquisition, re-resets the PLL on timeout or lock loss, and counts lock-loss events.

---
 rtl/pll_reset_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the LPDDR2 clock PLL from the free-running reference clock.
//   It pulses the PLL reset, waits for a synchronised and qualified lock,
//   and then releases the PHY, controller and user resets in that order
//   with programmable gaps. A lock that never arrives causes the PLL to be
//   re-reset. A lock lost after release pulls every reset back in, re-resets
//   the PLL and bumps a saturating event counter.
//
// Ports
//   clk            in   free-running reference clock (same source as PLL refclk)
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL lock indicator, asynchronous to clk
//   pll_rst        out  active-high PLL reset
//   phy_reset_n    out  active-low PHY reset
//   ctrl_reset_n   out  active-low controller reset
//   user_reset_n   out  active-low user-logic reset
//   ready          out  high only while in RUN
//   state_o        out  current state encoding (debug)
//   lock_loss_cnt  out  saturating count of lock losses after release began
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int PHY_TO_CTRL_CYCLES  = 64,
  parameter int CTRL_TO_USER_CYCLES = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int CNT_W               = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       phy_reset_n,
  output logic       ctrl_reset_n,
  output logic       user_reset_n,
  output logic       ready,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_REL_PHY   = 3'd3;
  localparam logic [2:0] S_REL_CTRL  = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;

  // Each load value is "cycles - 1" because the state also occupies the
  // cycle in which the counter reads zero.
  localparam logic [CNT_W-1:0] C_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_P2C     = CNT_W'(PHY_TO_CTRL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_C2U     = CNT_W'(CTRL_TO_USER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pll_rst;
  logic                   r_phy_n;
  logic                   r_ctrl_n;
  logic                   r_user_n;
  logic                   r_ready;
  logic [7:0]             r_loss_cnt;

  logic                   w_lk_s;
  logic                   w_cnt_zero;
  logic [CNT_W-1:0]       w_cnt_dec;
  logic [2:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_loss;

  assign w_lk_s     = r_sync[SYNC_STAGES-1];
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  // pll_locked comes from the PLL's own domain; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Next-state and counter logic. In the release states and RUN a low lock
  // wins over an expiring counter, so a release never happens on a lost lock.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss      = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = C_TIMEOUT;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lk_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = C_STABLE;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = C_PLL_RST;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      S_STABLE: begin
        // A dropout before release is a glitch: restart the lock wait
        // without touching the PLL or the loss counter.
        if (!w_lk_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = C_TIMEOUT;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_REL_PHY;
          w_cnt_nxt   = C_P2C;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      S_REL_PHY: begin
        if (!w_lk_s) begin
          w_loss = 1'b1;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_REL_CTRL;
          w_cnt_nxt   = C_C2U;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      S_REL_CTRL: begin
        if (!w_lk_s) begin
          w_loss = 1'b1;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      S_RUN: begin
        if (!w_lk_s) begin
          w_loss = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = C_PLL_RST;
      end
    endcase
    if (w_loss) begin
      w_state_nxt = S_PLL_RST;
      w_cnt_nxt   = C_PLL_RST;
    end
  end

  // Outputs are registered straight from the next state, so they change on
  // the same edge as the state and are glitch-free. Decoding the resets as
  // nested state ranges keeps the release order intact by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_PLL_RST;
      r_cnt      <= C_PLL_RST;
      r_pll_rst  <= 1'b1;
      r_phy_n    <= 1'b0;
      r_ctrl_n   <= 1'b0;
      r_user_n   <= 1'b0;
      r_ready    <= 1'b0;
      r_loss_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pll_rst <= (w_state_nxt == S_PLL_RST);
      r_phy_n   <= (w_state_nxt == S_REL_PHY) || (w_state_nxt == S_REL_CTRL) ||
                   (w_state_nxt == S_RUN);
      r_ctrl_n  <= (w_state_nxt == S_REL_CTRL) || (w_state_nxt == S_RUN);
      r_user_n  <= (w_state_nxt == S_RUN);
      r_ready   <= (w_state_nxt == S_RUN);
      if (w_loss && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  assign pll_rst       = r_pll_rst;
  assign phy_reset_n   = r_phy_n;
  assign ctrl_reset_n  = r_ctrl_n;
  assign user_reset_n  = r_user_n;
  assign ready         = r_ready;
  assign state_o       = r_state;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Self-checking bench for pll_reset_sequencer with shortened cycle
//   parameters. A table of per-step vectors covers the basic power-up
//   sequence; hand-written sequences cover lock loss in RUN, the glitch in
//   STABLE, loss coinciding with the REL_CTRL expiry, asynchronous reset,
//   the lock timeout and counter saturation.
module tb_pll_reset_sequencer;

  localparam int P_SYNC    = 2;
  localparam int P_STABLE  = 8;
  localparam int P_P2C     = 4;
  localparam int P_C2U     = 4;
  localparam int P_TIMEOUT = 32;
  localparam int P_PLLRST  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       phy_reset_n;
  logic       ctrl_reset_n;
  logic       user_reset_n;
  logic       ready;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         adv;
    logic       locked;
    logic [2:0] st;
    logic       pr;
    logic       phy;
    logic       ctrl;
    logic       user;
    logic       rdy;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[14];

  pll_reset_sequencer #(
    .SYNC_STAGES        (P_SYNC),
    .LOCK_STABLE_CYCLES (P_STABLE),
    .PHY_TO_CTRL_CYCLES (P_P2C),
    .CTRL_TO_USER_CYCLES(P_C2U),
    .LOCK_TIMEOUT_CYCLES(P_TIMEOUT),
    .PLL_RST_CYCLES     (P_PLLRST),
    .CNT_W              (17)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .phy_reset_n  (phy_reset_n),
    .ctrl_reset_n (ctrl_reset_n),
    .user_reset_n (user_reset_n),
    .ready        (ready),
    .state_o      (state_o),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Ordering invariants that must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if ((ctrl_reset_n && !phy_reset_n) || (user_reset_n && !ctrl_reset_n) ||
          (ready !== user_reset_n) || (pll_rst && phy_reset_n)) begin
        bad++;
        $display("[TB] FAIL invariant @%0t: pll_rst=%b phy=%b ctrl=%b user=%b ready=%b",
                 $time, pll_rst, phy_reset_n, ctrl_reset_n, user_reset_n, ready);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int adv, input logic locked);
    pll_locked = locked;
    repeat (adv) step();
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic pr,
                             input logic phy, input logic ctrl, input logic user,
                             input logic rdy, input logic [7:0] loss);
    total++;
    if ({state_o, pll_rst, phy_reset_n, ctrl_reset_n, user_reset_n, ready, lock_loss_cnt} !==
        {st, pr, phy, ctrl, user, rdy, loss}) begin
      bad++;
      $display("[TB] FAIL %s: got st=%0d pr=%b phy=%b ctrl=%b user=%b rdy=%b loss=%0d, want st=%0d pr=%b phy=%b ctrl=%b user=%b rdy=%b loss=%0d",
               name, state_o, pll_rst, phy_reset_n, ctrl_reset_n, user_reset_n, ready,
               lock_loss_cnt, st, pr, phy, ctrl, user, rdy, loss);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  // Steps until state_o equals target; running out of budget is a failure.
  task automatic waitState(input string name, input logic [2:0] target, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (state_o == target) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("[TB] FAIL %s: state %0d not reached in %0d cycles, got %0d",
               name, target, budget, state_o);
    end
  endtask

  // Holds reset across one edge and releases it just after that edge, so the
  // next rising edge is the first one out of reset.
  task automatic doReset(input logic locked);
    pll_locked = locked;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_values", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    rst_n = 1'b1;

    // Basic sequence: edge numbers counted from reset release; lock applied
    // before edge 10, lk_s high after edge 11, STABLE entered at edge 12.
    vecs[0]  = '{1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{6, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{7, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{3, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{3, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    vecs[13] = '{5, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].adv, vecs[i].locked);
      checkOutput($sformatf("basic_vec%0d", i), vecs[i].st, vecs[i].pr, vecs[i].phy,
                  vecs[i].ctrl, vecs[i].user, vecs[i].rdy, vecs[i].loss);
    end

    // Loss in RUN (at edge 33): lk_s low after edge 35, everything drops at 36.
    applyStimulus(1, 1'b0);
    checkOutput("run_loss_e34", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
    applyStimulus(1, 1'b0);
    checkOutput("run_loss_e35", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
    applyStimulus(1, 1'b0);
    checkOutput("run_loss_e36", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(2, 1'b1);
    checkOutput("relock_e38", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(1, 1'b1);
    checkOutput("relock_e39", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(1, 1'b1);
    checkOutput("relock_e40", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(7, 1'b1);
    checkOutput("relock_e47", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(1, 1'b1);
    checkOutput("relock_e48", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(4, 1'b1);
    checkOutput("relock_e52", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    applyStimulus(4, 1'b1);
    checkOutput("relock_e56", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);

    // Loss seen on the same edge that REL_CTRL's counter expires.
    doReset(1'b1);
    waitState("reach_rel_ctrl", 3'd4, 60);
    applyStimulus(1, 1'b1);
    applyStimulus(1, 1'b0);
    checkOutput("relctrl_x2", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b0);
    checkOutput("relctrl_x3", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b0);
    checkOutput("relctrl_x4", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Asynchronous reset while in RUN, sampled before any further clk edge.
    pll_locked = 1'b1;
    waitState("reach_run", 3'd5, 60);
    checkOutput("run_before_rst", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Lock timeout: pll_rst high for 3 edges in every 35, nothing else moves.
    pll_locked = 1'b0;
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 75; e++) begin
      logic exp_pr;
      step();
      exp_pr = ((e % (P_PLLRST + P_TIMEOUT)) < P_PLLRST);
      checkOutput($sformatf("timeout_e%0d", e), exp_pr ? 3'd0 : 3'd1, exp_pr,
                  1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // One-cycle lk_s dropout while STABLE's counter reads 5.
    doReset(1'b1);
    applyStimulus(4, 1'b1);
    checkOutput("glitch_e4", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b0);
    checkOutput("glitch_e5", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b1);
    checkOutput("glitch_e6", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b1);
    checkOutput("glitch_e7", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b1);
    checkOutput("glitch_e8", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(7, 1'b1);
    checkOutput("glitch_e15", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b1);
    checkOutput("glitch_e16", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // 300 lock losses from REL_PHY; the counter must stop at 255.
    doReset(1'b1);
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b1;
      waitState($sformatf("sat_phy%0d", i), 3'd3, 60);
      pll_locked = 1'b0;
      waitState($sformatf("sat_rst%0d", i), 3'd0, 10);
      checkValue($sformatf("sat_cnt%0d", i), int'(lock_loss_cnt), (i > 255) ? 255 : i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
